// File: rtl/timer_ctrl_if.sv
// Configuration, control and status bundle for timer_ctrl.
// The pause input exists only when TIMER_CTRL_PAUSE_EN is defined.
interface timer_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  // A configuration transfers on a rising clk edge where cfg_valid && cfg_ready.
  // The master holds cfg_valid and the cfg_* fields stable until that edge.
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [WIDTH-1:0]      cfg_period;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic                  cfg_periodic;
  logic                  start;
  logic                  stop;
`ifdef TIMER_CTRL_PAUSE_EN
  logic                  pause;
`endif
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  tick;
  logic                  done;

  modport master (
    input  cfg_ready, count, busy, tick, done,
    output cfg_valid, cfg_period, cfg_prescale, cfg_periodic, start, stop
`ifdef TIMER_CTRL_PAUSE_EN
    , pause
`endif
  );

  modport slave (
    output cfg_ready, count, busy, tick, done,
    input  cfg_valid, cfg_period, cfg_prescale, cfg_periodic, start, stop
`ifdef TIMER_CTRL_PAUSE_EN
    , pause
`endif
  );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable up-counter sequencer: config handshake, arm, prescaled run, terminate.
// Optional RUN freeze input enabled by TIMER_CTRL_PAUSE_EN.
module timer_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.slave  bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_nxt;
  logic [WIDTH-1:0]      count_q, count_nxt;
  logic [WIDTH-1:0]      period_q, period_nxt;
  logic [PRESCALE_W-1:0] prescale_q, prescale_nxt;
  logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_nxt;
  logic                  periodic_q, periodic_nxt;
  logic                  tick_q, tick_nxt;
  logic                  done_q, done_nxt;
  logic                  cfg_hs;
  logic                  hold;

  assign cfg_hs = bus.cfg_valid && bus.cfg_ready;

`ifdef TIMER_CTRL_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      psc_cnt_q  <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      count_q    <= count_nxt;
      period_q   <= period_nxt;
      prescale_q <= prescale_nxt;
      psc_cnt_q  <= psc_cnt_nxt;
      periodic_q <= periodic_nxt;
      tick_q     <= tick_nxt;
      done_q     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    count_nxt    = count_q;
    period_nxt   = period_q;
    prescale_nxt = prescale_q;
    psc_cnt_nxt  = psc_cnt_q;
    periodic_nxt = periodic_q;
    tick_nxt     = 1'b0;
    done_nxt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_hs) begin
          period_nxt   = bus.cfg_period;
          prescale_nxt = bus.cfg_prescale;
          periodic_nxt = bus.cfg_periodic;
          state_nxt    = ARMED;
        end
      end
      ARMED: begin
        if (bus.stop) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (bus.start) begin
          count_nxt   = '0;
          psc_cnt_nxt = '0;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          count_nxt   = '0;
          psc_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else if (!hold) begin
          if (psc_cnt_q == prescale_q) begin
            psc_cnt_nxt = '0;
            // Compare before incrementing so the count never wraps past period.
            if (count_q != period_q) begin
              count_nxt = count_q + 1'b1;
            end else begin
              tick_nxt = 1'b1;
              if (periodic_q) begin
                count_nxt = '0;
              end else begin
                done_nxt  = 1'b1;
                state_nxt = DONE;
              end
            end
          end else begin
            psc_cnt_nxt = psc_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.stop) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (bus.start) begin
          // A simultaneous cfg handshake still completes but its fields are dropped.
          count_nxt   = '0;
          psc_cnt_nxt = '0;
          state_nxt   = RUN;
        end else if (cfg_hs) begin
          period_nxt   = bus.cfg_period;
          prescale_nxt = bus.cfg_prescale;
          periodic_nxt = bus.cfg_periodic;
          state_nxt    = ARMED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.count     = count_q;
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed and randomized bench for timer_ctrl against an arithmetic timing model.
module tb_timer_ctrl;
  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         vectors;
  int         miscompares;
  logic [WIDTH-1:0] exp_q[$];

  timer_ctrl_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) ifc();

  timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int per, input int psc, input int periodic);
    logic accepted;
    logic ready_seen;
    accepted         = 1'b0;
    ifc.cfg_valid    = 1'b1;
    ifc.cfg_period   = per[WIDTH-1:0];
    ifc.cfg_prescale = psc[PRESCALE_W-1:0];
    ifc.cfg_periodic = periodic[0];
    for (int i = 0; i < 20; i++) begin
      ready_seen = ifc.cfg_ready;
      cyc();
      if (ready_seen) begin
        accepted = 1'b1;
        break;
      end
    end
    ifc.cfg_valid = 1'b0;
    chk("cfg_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic do_start();
    ifc.start = 1'b1;
    cyc();
    ifc.start = 1'b0;
  endtask

  task automatic do_stop();
    ifc.stop = 1'b1;
    cyc();
    ifc.stop = 1'b0;
    chk("stop_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("stop_count", {24'd0, ifc.count}, 32'd0);
    chk("stop_tick", {31'd0, ifc.tick}, 32'd0);
  endtask

  // Expected outputs k cycles after the start edge: the count advances once per
  // (psc+1) cycles and terminal is reached every (per+1)*(psc+1) cycles.
  function automatic void model(input int k, input int per, input int psc, input int periodic,
                                output int cnt, output int tk, output int dn, output int bsy);
    int p;
    int len;
    p   = psc + 1;
    len = p * (per + 1);
    if (periodic != 0) begin
      cnt = (k / p) % (per + 1);
      tk  = (k > 0 && (k % len) == 0) ? 1 : 0;
      dn  = 0;
      bsy = 1;
    end else if (k < len) begin
      cnt = k / p;
      tk  = 0;
      dn  = 0;
      bsy = 1;
    end else begin
      cnt = per;
      tk  = (k == len) ? 1 : 0;
      dn  = tk;
      bsy = 0;
    end
  endfunction

  // Starts the timer with the already-latched config and checks ncyc cycles.
  task automatic run_check(input int per, input int psc, input int periodic, input int ncyc);
    int cnt, tk, dn, bsy;
    logic [WIDTH-1:0] exp_cnt;
    exp_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      model(k, per, psc, periodic, cnt, tk, dn, bsy);
      exp_q.push_back(cnt[WIDTH-1:0]);
    end
    do_start();
    for (int k = 0; k < ncyc; k++) begin
      model(k, per, psc, periodic, cnt, tk, dn, bsy);
      exp_cnt = exp_q.pop_front();
      chk($sformatf("count k=%0d", k), {24'd0, ifc.count}, {24'd0, exp_cnt});
      chk($sformatf("tick k=%0d", k), {31'd0, ifc.tick}, tk);
      chk($sformatf("done k=%0d", k), {31'd0, ifc.done}, dn);
      chk($sformatf("busy k=%0d", k), {31'd0, ifc.busy}, bsy);
      if (k < ncyc - 1) cyc();
    end
  endtask

  initial begin
    int per, psc, periodic, ncyc;
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    ifc.cfg_valid    = 1'b0;
    ifc.cfg_period   = '0;
    ifc.cfg_prescale = '0;
    ifc.cfg_periodic = 1'b0;
    ifc.start        = 1'b0;
    ifc.stop         = 1'b0;
`ifdef TIMER_CTRL_PAUSE_EN
    ifc.pause        = 1'b0;
`endif
    repeat (3) cyc();
    chk("rst_count", {24'd0, ifc.count}, 32'd0);
    chk("rst_ready", {31'd0, ifc.cfg_ready}, 32'd1);
    rst = 1'b0;
    cyc();
    chk("init_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("init_busy", {31'd0, ifc.busy}, 32'd0);
    chk("init_tick", {31'd0, ifc.tick}, 32'd0);
    chk("init_done", {31'd0, ifc.done}, 32'd0);

    // reset mid-RUN
    do_cfg(5, 0, 0);
    do_start();
    cyc();
    cyc();
    chk("midrun_count", {24'd0, ifc.count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", {24'd0, ifc.count}, 32'd0);
    chk("arst_busy", {31'd0, ifc.busy}, 32'd0);
    chk("arst_ready", {31'd0, ifc.cfg_ready}, 32'd1);
    chk("arst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    cyc();
    rst = 1'b0;
    do_start();
    chk("idle_start_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("idle_start_busy", {31'd0, ifc.busy}, 32'd0);
    cyc();
    chk("idle_start_count", {24'd0, ifc.count}, 32'd0);

    // one-shot period 3, then restart from DONE with retained config
    do_cfg(3, 0, 0);
    chk("armed_ready", {31'd0, ifc.cfg_ready}, 32'd0);
    run_check(3, 0, 0, 8);
    chk("done_state", {30'd0, dbg_state}, {30'd0, S_DONE});
    chk("done_ready", {31'd0, ifc.cfg_ready}, 32'd1);
    run_check(3, 0, 0, 6);

    // start and stop together in DONE
    ifc.start = 1'b1;
    ifc.stop  = 1'b1;
    cyc();
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    chk("ss_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("ss_count", {24'd0, ifc.count}, 32'd0);

    // full-range one-shot
    do_cfg(255, 0, 0);
    run_check(255, 0, 0, 260);
    chk("full_count", {24'd0, ifc.count}, 32'd255);
    do_stop();

    // periodic with prescale
    do_cfg(2, 2, 1);
    run_check(2, 2, 1, 30);
    do_stop();

    // period 0, prescale 0: tick every cycle
    do_cfg(0, 0, 1);
    run_check(0, 0, 1, 10);
    do_stop();
    chk("p0_busy", {31'd0, ifc.busy}, 32'd0);

    // cfg offered while ARMED is refused; the latched config is used
    do_cfg(7, 1, 0);
    ifc.cfg_valid  = 1'b1;
    ifc.cfg_period = 8'd2;
    cyc();
    chk("armed_noaccept_ready", {31'd0, ifc.cfg_ready}, 32'd0);
    chk("armed_noaccept_state", {30'd0, dbg_state}, {30'd0, S_ARMED});
    ifc.cfg_valid = 1'b0;
    run_check(7, 1, 0, 20);
    do_stop();

    // randomized configurations
    for (int r = 0; r < 20; r++) begin
      per      = $urandom_range(0, 15);
      psc      = $urandom_range(0, 3);
      periodic = $urandom_range(0, 1);
      ncyc     = (periodic != 0) ? 2 * (per + 1) * (psc + 1) + 3 : (per + 1) * (psc + 1) + 4;
      do_cfg(per, psc, periodic);
      run_check(per, psc, periodic, ncyc);
      do_stop();
    end

`ifdef TIMER_CTRL_PAUSE_EN
    // pause freezes the count for three cycles at count 2
    do_cfg(4, 0, 0);
    do_start();
    cyc();
    cyc();
    chk("pause_pre", {24'd0, ifc.count}, 32'd2);
    ifc.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pause_hold", {24'd0, ifc.count}, 32'd2);
      chk("pause_busy", {31'd0, ifc.busy}, 32'd1);
    end
    ifc.pause = 1'b0;
    cyc();
    chk("pause_k6", {24'd0, ifc.count}, 32'd3);
    cyc();
    chk("pause_k7", {24'd0, ifc.count}, 32'd4);
    chk("pause_k7_done", {31'd0, ifc.done}, 32'd0);
    cyc();
    chk("pause_k8_done", {31'd0, ifc.done}, 32'd1);
    chk("pause_k8_tick", {31'd0, ifc.tick}, 32'd1);
    do_stop();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Programmable sequencer for a WIDTH-bit up-counter datapath.
- Accepts a configuration (terminal value, prescale, one-shot/periodic) over a valid/ready handshake.
- Arms, runs, prescales and terminates the count.
- Drives the counter value, a per-period tick and a one-shot done pulse to downstream logic.
- Sits between the register/control plane and any counter-based timing consumer.

Parameters:
WIDTH, 8, counter and period width
PRESCALE_W, 4, prescaler divider width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (state IDLE or DONE)
cfg_period  input  WIDTH  terminal count value
cfg_prescale  input  PRESCALE_W  count advances every cfg_prescale+1 cycles
cfg_periodic  input  1  1 = reload and continue at terminal, 0 = one-shot
start  input  1  begin counting (ARMED or DONE only)
stop  input  1  abort to IDLE
count  output  WIDTH  current count value
busy  output  1  high while state RUN
tick  output  1  one-cycle pulse on terminal count reached
done  output  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset values (async on rst high, held while high):
  - state IDLE; count 0; tick 0; done 0; busy 0; cfg_ready 1.
  - Internal period/prescale/periodic/prescale-counter registers all 0.
- All outputs are registered. cfg_ready and busy are decoded from the registered state.
- FSM states: IDLE, ARMED, RUN, DONE.
- IDLE:
  - cfg_valid && cfg_ready latches cfg_period, cfg_prescale, cfg_periodic -> ARMED.
  - start is ignored in IDLE.
- ARMED:
  - start -> RUN; count <= 0; prescale counter <= 0.
  - stop -> IDLE.
  - cfg_ready is 0 in ARMED.
- RUN:
  - Prescale counter increments every cycle. Strobe when prescale counter == latched prescale; the counter then clears to 0.
  - On strobe, if count != period: count <= count + 1.
  - On strobe, if count == period: tick <= 1 for one cycle.
    - Periodic: count <= 0, stay RUN.
    - One-shot: count holds at period, done <= 1 for one cycle, -> DONE.
  - stop -> IDLE; count <= 0; no tick or done.
- DONE:
  - count holds; cfg_ready = 1.
  - cfg handshake -> ARMED with new config.
  - start -> RUN with retained config, count <= 0.
  - stop -> IDLE; count <= 0.
- Priority in the same cycle: stop > start > cfg handshake.
  - In DONE with start and cfg_valid both high, start wins and cfg_ready is still 1. The handshake completes but the config is discarded. Masters must not assert both.
- Latency:
  - From the start edge to the done/tick assertion edge: (period+1)*(prescale+1) cycles.
  - Periodic tick spacing is the same value.
- Boundary conditions:
  - period = 0: terminal on every strobe. With prescale = 0, tick is high every cycle in periodic mode.
  - period = 2^WIDTH-1: full-range count. Arithmetic is never allowed to wrap past period, so there is no unintended rollover.
  - rst asserted mid-RUN: immediate return to reset values. No tick or done is emitted.
  - cfg_valid outside IDLE/DONE: not accepted. The master holds it until cfg_ready.

Optional Feature:
Macro TIMER_CTRL_PAUSE_EN.
- Defined: adds input port pause (1 bit), placed after stop.
  - While pause is high in RUN, the prescale counter and count freeze and no strobe occurs. busy stays 1.
  - stop still overrides pause.
  - pause has no effect in other states.
- Undefined: the port is absent and RUN always advances.

Test Plan:
- Reset during RUN (period=5, count=2) -> all outputs 0 immediately and state IDLE; a subsequent start with no cfg is ignored.
- Config period=3, prescale=0, periodic=0, then start -> count 0,1,2,3 on consecutive cycles. done and tick high exactly 4 cycles after the start edge. busy drops, count holds 3, cfg_ready=1.
- period=2, prescale=2, periodic=1, run 30 cycles -> tick every 9 cycles (3 pulses). count sequence 0,0,0,1,1,1,2,2,2,0. done never asserted.
- period=0, prescale=0, periodic=1 -> tick high every cycle and count constant 0. stop -> IDLE next edge, tick 0.
- DONE with start and stop asserted together -> IDLE, count 0. Then a cfg handshake in IDLE with period=255, prescale=0, one-shot, start -> done exactly 256 cycles later, count=255.
- With TIMER_CTRL_PAUSE_EN: period=4, prescale=0, pause high for 3 cycles at count=2 -> count stays 2. done is delayed by exactly 3 cycles (8 cycles after start instead of 5).
